// File: rtl/mul_exp_driver_pkg.sv
// Shared types for the masked GF(2^8) exponentiation driver and its serial multiplier.
package mul_exp_driver_pkg;

    localparam int MASK_D = 1;
    localparam int GF_W   = 8;
    localparam int S_W    = (MASK_D + 1) * GF_W;

    typedef logic [S_W-1:0]  state_t;
    typedef logic [GF_W:0]   base_poly_t;

    // Share 0 carries the value 1, every other share is zero.
    localparam state_t ONE_STATE = state_t'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SQR_REQ  = 3'd1,
        ST_SQR_WAIT = 3'd2,
        ST_MUL_REQ  = 3'd3,
        ST_MUL_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } exp_state_t;

endpackage

// File: rtl/mul_exp_driver_if.sv
// Bundle between a serial masked multiplier and whoever feeds it operands.
interface mul_if;
    import mul_exp_driver_pkg::*;

    state_t     p1;
    state_t     p2;
    base_poly_t P;
    logic       drdy_i;
    logic       drdy_o;
    state_t     out;

    modport mul (input p1, p2, P, drdy_i, output drdy_o, out);
    modport ctl (output p1, p2, P, drdy_i, input drdy_o, out);

endinterface

// File: rtl/mul_exp_driver.sv
// MSB-first square-and-multiply controller over masked shares, issuing one
// request at a time to an external serial multiplier of arbitrary latency.
module mul_exp_driver
    import mul_exp_driver_pkg::*;
#(
    parameter int d          = MASK_D,
    parameter int E_W        = 8,
    parameter int CONST_TIME = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [(d+1)*GF_W-1:0]   base,
    input  logic [E_W-1:0]          exp,
    input  base_poly_t              P,
    output logic                    busy,
    output logic                    done,
    output logic [(d+1)*GF_W-1:0]   result,
    output logic [(d+1)*GF_W-1:0]   m_p1,
    output logic [(d+1)*GF_W-1:0]   m_p2,
    output base_poly_t              m_P,
    output logic                    m_drdy_i,
    input  logic                    m_drdy_o,
    input  logic [(d+1)*GF_W-1:0]   m_out,
    output exp_state_t              dbg_state
);

    localparam int W_S   = (d + 1) * GF_W;
    localparam int IDX_W = (E_W > 1) ? $clog2(E_W) : 1;
    localparam logic [W_S-1:0] L_ONE = W_S'(ONE_STATE);

    // Handshake: m_drdy_i is a one-cycle request; m_p1/m_p2/m_P hold from that
    // cycle until the one-cycle m_drdy_o is taken, which only a *_WAIT state does.
    exp_state_t       r_state;
    exp_state_t       w_state_nxt;
    logic [W_S-1:0]   r_base;
    logic [E_W-1:0]   r_exp;
    base_poly_t       r_P;
    logic [W_S-1:0]   r_acc;
    logic [W_S-1:0]   w_acc_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [W_S-1:0]   r_result;
    logic [W_S-1:0]   r_p1;
    logic [W_S-1:0]   r_p2;
    logic             w_bit;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;
        w_bit       = r_exp[r_idx];
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SQR_REQ;
                    w_acc_nxt   = L_ONE;
                    w_idx_nxt   = IDX_W'(E_W - 1);
                end
            end
            ST_SQR_REQ: w_state_nxt = ST_SQR_WAIT;
            ST_SQR_WAIT: begin
                if (m_drdy_o) begin
                    w_acc_nxt = m_out;
                    if ((CONST_TIME == 0) && !w_bit) begin
                        if (r_idx == '0) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_idx_nxt   = r_idx - IDX_W'(1);
                            w_state_nxt = ST_SQR_REQ;
                        end
                    end else begin
                        w_state_nxt = ST_MUL_REQ;
                    end
                end
            end
            ST_MUL_REQ: w_state_nxt = ST_MUL_WAIT;
            ST_MUL_WAIT: begin
                if (m_drdy_o) begin
                    // With a zero exponent bit the product is a dummy and is dropped.
                    if (w_bit) begin
                        w_acc_nxt = m_out;
                    end
                    if (r_idx == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx - IDX_W'(1);
                        w_state_nxt = ST_SQR_REQ;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_P      <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_p1     <= '0;
            r_p2     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
            if ((r_state == ST_IDLE) && start) begin
                r_base <= base;
                r_exp  <= exp;
                r_P    <= P;
            end
            // Operands are registered on entry to a request state so they stay put through the wait.
            if (w_state_nxt == ST_SQR_REQ) begin
                r_p1 <= w_acc_nxt;
                r_p2 <= w_acc_nxt;
            end else if (w_state_nxt == ST_MUL_REQ) begin
                r_p1 <= w_acc_nxt;
                r_p2 <= r_base;
            end
            if (w_state_nxt == ST_DONE) begin
                r_result <= w_acc_nxt;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign m_drdy_i  = (r_state == ST_SQR_REQ) || (r_state == ST_MUL_REQ);
    assign m_p1      = r_p1;
    assign m_p2      = r_p2;
    assign m_P       = r_P;
    assign result    = r_result;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mul_exp_driver.sv
// Bench for mul_exp_driver: one constant-time and one variable-time instance fed the
// same requests, each served by a behavioural masked GF(2^8) multiplier.
module tb_mul_exp_driver;
    import mul_exp_driver_pkg::*;

    localparam int E_W = 8;
    localparam int NI  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    state_t          base_i;
    logic [E_W-1:0]  exp_i;
    base_poly_t      p_i;

    logic            busy   [NI];
    logic            done   [NI];
    logic            drdy_i [NI];
    state_t          result [NI];
    state_t          p1     [NI];
    state_t          p2     [NI];
    base_poly_t      mP     [NI];
    exp_state_t      dbg    [NI];

    logic            mdl_pulse [NI];
    logic            spur      [NI];
    state_t          mdl_out   [NI];

    bit              pending   [NI];
    int              rem       [NI];
    state_t          cap_p1    [NI];
    state_t          cap_p2    [NI];
    base_poly_t      cap_P     [NI];
    int              req_cnt   [NI];
    int              stab_err  [NI];
    int              done_cnt  [NI];
    state_t          last_res  [NI];
    int              fixed_lat;

    int              tests_run;
    int              tests_failed;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        mul_if u_mif ();
        assign u_mif.drdy_o = mdl_pulse[g] | spur[g];
        assign u_mif.out    = mdl_out[g];
        assign p1[g]        = u_mif.p1;
        assign p2[g]        = u_mif.p2;
        assign mP[g]        = u_mif.P;
        assign drdy_i[g]    = u_mif.drdy_i;

        mul_exp_driver #(
            .E_W        (E_W),
            .CONST_TIME (g == 0 ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .base      (base_i),
            .exp       (exp_i),
            .P         (p_i),
            .busy      (busy[g]),
            .done      (done[g]),
            .result    (result[g]),
            .m_p1      (u_mif.p1),
            .m_p2      (u_mif.p2),
            .m_P       (u_mif.P),
            .m_drdy_i  (u_mif.drdy_i),
            .m_drdy_o  (u_mif.drdy_o),
            .m_out     (u_mif.out),
            .dbg_state (dbg[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b, input base_poly_t p);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (b[i]) r ^= ({8'h00, a} << i);
        for (int k = 14; k >= 8; k--) if (r[k]) r ^= ({7'h00, p} << (k - 8));
        return r[7:0];
    endfunction

    function automatic logic [7:0] recomb(input state_t s);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i <= MASK_D; i++) x ^= s[i*GF_W +: GF_W];
        return x;
    endfunction

    function automatic state_t mask_val(input logic [7:0] v);
        state_t     s;
        logic [7:0] r;
        logic [7:0] x;
        s = '0;
        x = v;
        for (int i = 1; i <= MASK_D; i++) begin
            r = 8'($urandom);
            s[i*GF_W +: GF_W] = r;
            x ^= r;
        end
        s[GF_W-1:0] = x;
        return s;
    endfunction

    // b^e as e repeated multiplications, independent of bit order.
    function automatic logic [7:0] ref_pow(input logic [7:0] b, input logic [E_W-1:0] e, input base_poly_t p);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < int'(e); i++) r = gmul(r, b, p);
        return r;
    endfunction

    // Multiplier model and done monitor, both sampled on the falling edge.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst) begin
                pending[g]   = 1'b0;
                mdl_pulse[g] = 1'b0;
                mdl_out[g]   = '0;
            end else begin
                mdl_pulse[g] = 1'b0;
                if (done[g]) begin
                    done_cnt[g]++;
                    last_res[g] = result[g];
                end
                if (pending[g]) begin
                    if (p1[g] !== cap_p1[g] || p2[g] !== cap_p2[g] || mP[g] !== cap_P[g]) stab_err[g]++;
                    if (drdy_i[g]) stab_err[g]++;
                    rem[g]--;
                    if (rem[g] == 0) begin
                        mdl_pulse[g] = 1'b1;
                        mdl_out[g]   = mask_val(gmul(recomb(cap_p1[g]), recomb(cap_p2[g]), cap_P[g]));
                        pending[g]   = 1'b0;
                    end
                end else if (drdy_i[g]) begin
                    pending[g] = 1'b1;
                    rem[g]     = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 20);
                    cap_p1[g]  = p1[g];
                    cap_p2[g]  = p2[g];
                    cap_P[g]   = mP[g];
                    req_cnt[g]++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // mode: 0 plain, 1 spurious response in SQR_REQ, 2 start pulses while busy, 3 start in done cycle
    task automatic run_op(input logic [7:0] b, input logic [E_W-1:0] e, input base_poly_t p,
                          input int mode, input string tag);
        int         d0 [NI];
        int         q0 [NI];
        int         s0 [NI];
        int         cyc;
        int         exp_req;
        bit         hit;
        logic [7:0] want;
        for (int g = 0; g < NI; g++) begin
            d0[g] = done_cnt[g];
            q0[g] = req_cnt[g];
            s0[g] = stab_err[g];
        end
        want   = ref_pow(b, e, p);
        base_i = mask_val(b);
        exp_i  = e;
        p_i    = p;
        start  = 1'b1;
        step();
        start  = 1'b0;
        if (mode == 1) begin
            for (int g = 0; g < NI; g++) begin
                tests_run++;
                if (dbg[g] !== ST_SQR_REQ) begin
                    tests_failed++;
                    $display("FAIL %s pre_state[%0d] got %0d want %0d", tag, g, int'(dbg[g]), int'(ST_SQR_REQ));
                end
            end
            spur[0] = 1'b1;
            spur[1] = 1'b1;
            step();
            spur[0] = 1'b0;
            spur[1] = 1'b0;
            for (int g = 0; g < NI; g++) begin
                tests_run++;
                if (dbg[g] !== ST_SQR_WAIT) begin
                    tests_failed++;
                    $display("FAIL %s post_state[%0d] got %0d want %0d", tag, g, int'(dbg[g]), int'(ST_SQR_WAIT));
                end
            end
        end
        cyc = 0;
        hit = 1'b0;
        while ((done_cnt[0] == d0[0] || done_cnt[1] == d0[1]) && cyc < 2000) begin
            step();
            cyc++;
            start = 1'b0;
            if (mode == 2 && busy[0] && busy[1] && !done[0] && !done[1] && $urandom_range(0, 3) == 0) begin
                start  = 1'b1;
                base_i = state_t'($urandom);
                exp_i  = E_W'($urandom);
                p_i    = base_poly_t'($urandom);
            end
            if (mode == 3 && !hit && (done[0] || done[1])) begin
                start = 1'b1;
                hit   = 1'b1;
            end
        end
        step();
        start = 1'b0;
        step();
        step();
        tests_run++;
        if (cyc >= 2000) begin
            tests_failed++;
            $display("FAIL %s timeout got %0d cycles want < 2000", tag, cyc);
        end
        for (int g = 0; g < NI; g++) begin
            exp_req = (g == 0) ? 2 * E_W : E_W + $countones(e);
            tests_run++;
            if (recomb(last_res[g]) !== want) begin
                tests_failed++;
                $display("FAIL %s result[%0d] b=%h e=%h got %h want %h", tag, g, b, e, recomb(last_res[g]), want);
            end
            tests_run++;
            if (req_cnt[g] - q0[g] != exp_req) begin
                tests_failed++;
                $display("FAIL %s req_count[%0d] got %0d want %0d", tag, g, req_cnt[g] - q0[g], exp_req);
            end
            tests_run++;
            if (done_cnt[g] - d0[g] != 1) begin
                tests_failed++;
                $display("FAIL %s done_count[%0d] got %0d want 1", tag, g, done_cnt[g] - d0[g]);
            end
            tests_run++;
            if (stab_err[g] - s0[g] != 0) begin
                tests_failed++;
                $display("FAIL %s operand_stability[%0d] got %0d errors want 0", tag, g, stab_err[g] - s0[g]);
            end
            tests_run++;
            if (dbg[g] !== ST_IDLE || busy[g] !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s idle_after[%0d] got state %0d busy %b want 0/0", tag, g, int'(dbg[g]), busy[g]);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if ({busy[g], done[g], drdy_i[g], result[g], p1[g], p2[g], mP[g]} !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d] got %h want 0", g,
                         {busy[g], done[g], drdy_i[g], result[g], p1[g], p2[g], mP[g]});
            end
            tests_run++;
            if (dbg[g] !== ST_IDLE) begin
                tests_failed++;
                $display("FAIL reset_state[%0d] got %0d want %0d", g, int'(dbg[g]), int'(ST_IDLE));
            end
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_known();
        fixed_lat = 3;
        run_op(8'h53, 8'd254, 9'h11B, 0, "inv53");
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (recomb(last_res[g]) !== 8'hCA) begin
                tests_failed++;
                $display("FAIL inv53_const[%0d] got %h want ca", g, recomb(last_res[g]));
            end
        end
        run_op(8'($urandom), 8'd0, 9'h11B, 0, "exp0");
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (recomb(last_res[g]) !== 8'h01) begin
                tests_failed++;
                $display("FAIL exp0_const[%0d] got %h want 01", g, recomb(last_res[g]));
            end
        end
        run_op(8'h57, 8'd1, 9'h11B, 0, "exp1");
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (recomb(last_res[g]) !== 8'h57) begin
                tests_failed++;
                $display("FAIL exp1_const[%0d] got %h want 57", g, recomb(last_res[g]));
            end
        end
    endtask

    task automatic test_spur_idle();
        int d0 [NI];
        for (int g = 0; g < NI; g++) d0[g] = done_cnt[g];
        spur[0] = 1'b1;
        spur[1] = 1'b1;
        step();
        spur[0] = 1'b0;
        spur[1] = 1'b0;
        step();
        step();
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (dbg[g] !== ST_IDLE || busy[g] !== 1'b0 || done_cnt[g] != d0[g]) begin
                tests_failed++;
                $display("FAIL spur_idle[%0d] got state %0d busy %b dones %0d want idle/0/%0d",
                         g, int'(dbg[g]), busy[g], done_cnt[g], d0[g]);
            end
            tests_run++;
            if (recomb(result[g]) !== 8'h57) begin
                tests_failed++;
                $display("FAIL spur_idle_result[%0d] got %h want 57", g, recomb(result[g]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int d0 [NI];
        int cyc;
        for (int g = 0; g < NI; g++) d0[g] = done_cnt[g];
        fixed_lat = 6;
        base_i = mask_val(8'($urandom));
        exp_i  = '1;
        p_i    = 9'h11B;
        start  = 1'b1;
        step();
        start  = 1'b0;
        cyc = 0;
        while (dbg[0] !== ST_MUL_WAIT && cyc < 200) begin
            step();
            cyc++;
        end
        tests_run++;
        if (cyc >= 200) begin
            tests_failed++;
            $display("FAIL rst_mid_reach got %0d cycles want < 200", cyc);
        end
        rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if ({busy[g], done[g], drdy_i[g], result[g], p1[g], p2[g], mP[g]} !== '0 || dbg[g] !== ST_IDLE) begin
                tests_failed++;
                $display("FAIL rst_mid_outputs[%0d] got %h state %0d want 0 idle", g,
                         {busy[g], done[g], drdy_i[g], result[g], p1[g], p2[g], mP[g]}, int'(dbg[g]));
            end
        end
        step();
        step();
        rst = 1'b1;
        step();
        spur[0] = 1'b1;
        spur[1] = 1'b1;
        step();
        spur[0] = 1'b0;
        spur[1] = 1'b0;
        repeat (5) step();
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if (dbg[g] !== ST_IDLE || busy[g] !== 1'b0 || done_cnt[g] != d0[g] || result[g] !== '0) begin
                tests_failed++;
                $display("FAIL rst_mid_stale[%0d] got state %0d busy %b dones %0d result %h want idle/0/%0d/0",
                         g, int'(dbg[g]), busy[g], done_cnt[g], result[g], d0[g]);
            end
        end
        fixed_lat = 0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        start        = 1'b0;
        spur[0]      = 1'b0;
        spur[1]      = 1'b0;
        base_i       = '0;
        exp_i        = '0;
        p_i          = '0;
        fixed_lat    = 3;

        test_reset();
        test_known();
        test_spur_idle();
        fixed_lat = 0;
        repeat (4) run_op(8'($urandom), E_W'($urandom), 9'h11B, 1, "spur_sqr");
        repeat (120) run_op(8'($urandom), E_W'($urandom), 9'h100 | 9'($urandom_range(0, 255)), 0, "random");
        repeat (10) run_op(8'($urandom), E_W'($urandom), 9'h11B, 2, "start_busy");
        repeat (10) run_op(8'($urandom), E_W'($urandom), 9'h11B, 3, "start_done");
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
